// File: rtl/money_irq_ctrl_pkg.sv
// Shared definitions for the coin-PIO interrupt controller: FSM states,
// PIO register offsets and default coin values.
package money_irq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_ADDR,
    S_RD_CAP,
    S_CLR,
    S_ACC
  } state_e;

  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

  localparam int COIN0_DEF = 1;
  localparam int COIN1_DEF = 5;
  localparam int COIN2_DEF = 10;

endpackage

// File: rtl/money_irq_ctrl_coin_value_sum.sv
// Maps the captured coin edge bits to a credit increment, combinationally.
module coin_value_sum
  import money_irq_ctrl_pkg::*;
#(
  parameter int COIN0_VAL = COIN0_DEF,
  parameter int COIN1_VAL = COIN1_DEF,
  parameter int COIN2_VAL = COIN2_DEF,
  parameter int CREDIT_W  = 8
) (
  input  logic [2:0]          cap_i,
  output logic [CREDIT_W+1:0] inc_o
);

  localparam logic [CREDIT_W+1:0] V0 = (CREDIT_W+2)'(COIN0_VAL);
  localparam logic [CREDIT_W+1:0] V1 = (CREDIT_W+2)'(COIN1_VAL);
  localparam logic [CREDIT_W+1:0] V2 = (CREDIT_W+2)'(COIN2_VAL);

  assign inc_o = (cap_i[0] ? V0 : '0) + (cap_i[1] ? V1 : '0) + (cap_i[2] ? V2 : '0);

endmodule

// File: rtl/money_irq_ctrl.sv
// Coin-acceptor controller: services the coin PIO interrupt, accumulates
// saturating credit, and arbitrates vend and refund requests.
module money_irq_ctrl
  import money_irq_ctrl_pkg::*;
#(
  parameter int COIN0_VAL = COIN0_DEF,
  parameter int COIN1_VAL = COIN1_DEF,
  parameter int COIN2_VAL = COIN2_DEF,
  parameter int CREDIT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pio_irq,
  output logic [1:0]          pio_address,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [2:0]          pio_writedata,
  input  logic [2:0]          pio_readdata,
  input  logic                vend_req,
  input  logic [CREDIT_W-1:0] vend_price,
  output logic                vend_ack,
  output logic                vend_nack,
  input  logic                refund_req,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amt,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W+1:0] CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q, refund_amt_q;
  logic [2:0]          cap_q, wd_q;
  logic [1:0]          addr_q;
  logic                cs_q, wn_q, ack_q, nack_q, rv_q, vend_blk_q;
  logic [CREDIT_W+1:0] inc, sum_w;
  logic [CREDIT_W-1:0] credit_d;

  coin_value_sum #(
    .COIN0_VAL(COIN0_VAL),
    .COIN1_VAL(COIN1_VAL),
    .COIN2_VAL(COIN2_VAL),
    .CREDIT_W (CREDIT_W)
  ) u_sum (
    .cap_i(cap_q),
    .inc_o(inc)
  );

  assign sum_w    = {2'b00, credit_q} + inc;
  assign credit_d = (sum_w > CREDIT_MAX) ? {CREDIT_W{1'b1}} : sum_w[CREDIT_W-1:0];

  // Bus outputs are registered on entry to each state; the INIT mask write is
  // registered during INIT and is on the bus as the FSM enters IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      credit_q     <= '0;
      cap_q        <= '0;
      refund_amt_q <= '0;
      ack_q        <= 1'b0;
      nack_q       <= 1'b0;
      rv_q         <= 1'b0;
      addr_q       <= PIO_DATA;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wd_q         <= '0;
      vend_blk_q   <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      nack_q <= 1'b0;
      rv_q   <= 1'b0;
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      wd_q   <= '0;
      if (!vend_req) vend_blk_q <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          addr_q  <= PIO_MASK;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          wd_q    <= 3'b111;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          addr_q <= PIO_DATA;
          if (pio_irq) begin
            addr_q  <= PIO_EDGE;
            state_q <= S_RD_ADDR;
          end else if (vend_req && !vend_blk_q) begin
            vend_blk_q <= 1'b1;
            if (credit_q >= vend_price) begin
              credit_q <= credit_q - vend_price;
              ack_q    <= 1'b1;
            end else begin
              nack_q <= 1'b1;
            end
          end else if (!vend_req && refund_req) begin
            refund_amt_q <= credit_q;
            rv_q         <= 1'b1;
            credit_q     <= '0;
          end
        end
        S_RD_ADDR: begin
          addr_q  <= PIO_EDGE;
          state_q <= S_RD_CAP;
        end
        S_RD_CAP: begin
          // Clear every edge bit; edges landing after this read are dropped.
          cap_q   <= pio_readdata;
          addr_q  <= PIO_EDGE;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          wd_q    <= 3'b111;
          state_q <= S_CLR;
        end
        S_CLR: begin
          addr_q  <= PIO_DATA;
          state_q <= S_ACC;
        end
        S_ACC: begin
          credit_q <= credit_d;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign pio_address    = addr_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = wd_q;
  assign vend_ack       = ack_q;
  assign vend_nack      = nack_q;
  assign refund_valid   = rv_q;
  assign refund_amt     = refund_amt_q;
  assign credit         = credit_q;

endmodule

// File: doc/money_irq_ctrl.md
MONEY_IRQ_CTRL -- requirements
Module: money_irq_ctrl

Interface
REQ-001 Parameter COIN0_VAL, default 1: credit units added for an edge captured on coin bit 0.
REQ-002 Parameter COIN1_VAL, default 5: credit units for coin bit 1.
REQ-003 Parameter COIN2_VAL, default 10: credit units for coin bit 2.
REQ-004 Parameter CREDIT_W, default 8: width of credit, price and refund.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pio_irq  in  1  interrupt from the 3-bit coin PIO.
REQ-008 pio_address  out  2  PIO register select.
REQ-009 pio_chipselect  out  1  PIO select.
REQ-010 pio_write_n  out  1  PIO write strobe, active low.
REQ-011 pio_writedata  out  3  PIO write data.
REQ-012 pio_readdata  in  3  PIO read data, valid one cycle after pio_address is driven.
REQ-013 vend_req  in  1  held high until vend_ack or vend_nack.
REQ-014 vend_price  in  CREDIT_W  price; stable while vend_req is high.
REQ-015 vend_ack / vend_nack  out  1 each  one-cycle result pulses.
REQ-016 refund_req  in  1  single-cycle request to return all credit.
REQ-017 refund_valid  out  1  one-cycle pulse; refund_amt  out  CREDIT_W  returned amount.
REQ-018 credit  out  CREDIT_W  current accumulated credit.

Function
REQ-019 FSM states: INIT, IDLE, RD_ADDR, RD_CAP, CLR, ACC.
REQ-020 INIT shall last exactly one cycle, driving address=2, chipselect=1, write_n=0, writedata=3'b111 to enable all IRQ bits, then go to IDLE.
REQ-021 Outside INIT and CLR, chipselect shall be 0, write_n 1 and writedata 0.
REQ-022 In IDLE, pio_irq=1 shall move to RD_ADDR; pio_irq has priority over vend_req and refund_req in the same cycle.
REQ-023 RD_ADDR shall drive address=3 for one cycle; RD_CAP shall keep address=3 and register pio_readdata into cap[2:0].
REQ-024 CLR shall write address=3 (chipselect=1, write_n=0) for one cycle, clearing the PIO edge capture.
REQ-025 ACC shall add, in one cycle, cap[0]*COIN0_VAL + cap[1]*COIN1_VAL + cap[2]*COIN2_VAL to credit and return to IDLE; the IRQ service sequence is 4 cycles.
REQ-026 Credit arithmetic shall use CREDIT_W+2 bits internally and saturate credit at 2^CREDIT_W-1.
REQ-027 cap=3'b000 (spurious IRQ) shall leave credit unchanged.
REQ-028 In IDLE with pio_irq=0 and vend_req=1: when credit >= vend_price, credit shall drop by vend_price and vend_ack shall pulse next cycle; otherwise only vend_nack shall pulse; credit equal to price is an ack.
REQ-029 After an ack or nack, a further vend shall not be evaluated until vend_req has been low for at least one cycle.
REQ-030 In IDLE with pio_irq=0, vend_req=0 and refund_req=1: refund_amt shall equal credit and refund_valid shall pulse, with credit cleared in the same update; a refund at zero credit shall pulse with refund_amt=0.
REQ-031 refund_req outside IDLE, or while blocked by higher priority, shall be dropped.
REQ-032 Coin edges arriving between RD_CAP and CLR are lost; this is an accepted limitation.

Reset
REQ-033 While reset=1: state=INIT, credit=0, cap=0, refund_amt=0, vend_ack=vend_nack=refund_valid=0, pio_address=0, chipselect=0, write_n=1, writedata=0.
REQ-034 Reset asserted mid-sequence shall abort it and discard cap; after release the FSM shall re-run INIT.

Structure
REQ-035 A shared package shall hold the FSM state enum, PIO register offsets (DATA=0, MASK=2, EDGE=3) and default coin values.
REQ-036 One sub-module, coin_value_sum, shall map cap[2:0] to a credit increment combinationally.

Verification
REQ-037 Reset release -> next cycle: address=2, write_n=0, writedata=7; IDLE one cycle later.
REQ-038 pio_irq with readdata=3'b101 in RD_CAP, credit 0 -> address=3 write in CLR; credit=11 after ACC.
REQ-039 credit=250, readdata=3'b100 -> credit=255 (saturated).
REQ-040 credit=15, vend_req with price=15 -> vend_ack, credit=0; a new request with price=1 -> vend_nack, credit=0.
REQ-041 pio_irq and vend_req in the same IDLE cycle -> IRQ serviced first, then vend evaluated against the updated credit.
REQ-042 credit=20, refund_req -> refund_valid with refund_amt=20, credit=0; reset asserted during CLR -> credit=0 and INIT re-run.
